// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
//   - FSM state encodings (ST_IDLE, ST_ACCESS)
//   - grant id encodings (GNT_CORE, GNT_LOAD)
//   - addr_err(): alignment / range check applied when a request is captured
package dmem_arb_pkg;

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_ACCESS = 1'b1;

    localparam logic GNT_CORE = 1'b0;
    localparam logic GNT_LOAD = 1'b1;

    // Rejects byte addresses that are not word aligned or that fall beyond the
    // 2^mem_aw words of memory.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned mem_aw);
        logic [31:0] hi_mask;
        hi_mask  = ~((32'd1 << (mem_aw + 32'd2)) - 32'd1);
        addr_err = (addr[1:0] != 2'b00) || ((addr & hi_mask) != 32'd0);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
//   master modport: requester/memory side (drives requests and mem_rdat)
//   slave modport : arbiter side (drives ready, responses and memory controls)
interface dmem_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned MEM_AW = 6
) ();

    logic              c_req_valid;
    logic              c_req_ready;
    logic              c_req_we;
    logic [31:0]       c_req_addr;
    logic [DATA_W-1:0] c_req_wdata;
    logic              c_rsp_valid;
    logic [DATA_W-1:0] c_rsp_rdata;
    logic              c_rsp_err;

    logic              l_req_valid;
    logic              l_req_ready;
    logic              l_req_we;
    logic [31:0]       l_req_addr;
    logic [DATA_W-1:0] l_req_wdata;
    logic              l_rsp_valid;
    logic [DATA_W-1:0] l_rsp_rdata;
    logic              l_rsp_err;

    logic [MEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdat;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_rdat;

    modport master (
        output c_req_valid, c_req_we, c_req_addr, c_req_wdata,
        input  c_req_ready, c_rsp_valid, c_rsp_rdata, c_rsp_err,
        output l_req_valid, l_req_we, l_req_addr, l_req_wdata,
        input  l_req_ready, l_rsp_valid, l_rsp_rdata, l_rsp_err,
        input  mem_addr, mem_wdat, mem_wen,
        output mem_rdat
    );

    modport slave (
        input  c_req_valid, c_req_we, c_req_addr, c_req_wdata,
        output c_req_ready, c_rsp_valid, c_rsp_rdata, c_rsp_err,
        input  l_req_valid, l_req_we, l_req_addr, l_req_wdata,
        output l_req_ready, l_rsp_valid, l_rsp_rdata, l_rsp_err,
        output mem_addr, mem_wdat, mem_wen,
        input  mem_rdat
    );

endinterface

// File: rtl/rr_pick2.sv
// Two-input round-robin picker, purely combinational.
//   req        in  2  pending requests, bit 0 = core, bit 1 = loader
//   last_grant in  1  id of the most recent grant (GNT_CORE / GNT_LOAD)
//   gnt        out 2  one-hot grant, same bit order as req; 0 when idle
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            // Contested: the port that did not win last time goes first.
            2'b11:   gnt = (last_grant == GNT_LOAD) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between the core load/store path and a
// loader/debug port. One transaction at a time: accept in IDLE, drive memory
// for one cycle in ACCESS, registered response the cycle after.
//   clk   in  clock, rising edge
//   rst_n in  asynchronous active-low reset
//   bus   slave modport of dmem_arbiter_if (requests, responses, memory)
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned MEM_AW = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
);

    logic              state_q;
    logic              last_grant_q;
    logic              we_q;
    logic              err_q;
    logic [MEM_AW-1:0] word_q;
    logic [DATA_W-1:0] wdata_q;

    logic              c_rsp_valid_q, l_rsp_valid_q;
    logic              c_rsp_err_q,   l_rsp_err_q;
    logic [DATA_W-1:0] c_rsp_rdata_q, l_rsp_rdata_q;

    logic [1:0]        req;
    logic [1:0]        gnt;
    logic              accept;
    logic              sel_we;
    logic [31:0]       sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [DATA_W-1:0] rsp_rdata;

    assign req = {bus.l_req_valid, bus.c_req_valid};

    rr_pick2 u_pick (
        .req        (req),
        .last_grant (last_grant_q),
        .gnt        (gnt)
    );

    assign accept          = (state_q == ST_IDLE) && (req != 2'b00);
    assign bus.c_req_ready = accept & gnt[0];
    assign bus.l_req_ready = accept & gnt[1];

    always_comb begin
        if (gnt[1]) begin
            sel_we    = bus.l_req_we;
            sel_addr  = bus.l_req_addr;
            sel_wdata = bus.l_req_wdata;
        end else begin
            sel_we    = bus.c_req_we;
            sel_addr  = bus.c_req_addr;
            sel_wdata = bus.c_req_wdata;
        end
    end

    // Stores and rejected accesses return zero data.
    always_comb begin
        rsp_rdata = '0;
        if (!we_q && !err_q) begin
            rsp_rdata = bus.mem_rdat;
        end
    end

    // Built from registers only, so an asynchronous reset kills the write
    // strobe immediately.
    assign bus.mem_wen  = (state_q == ST_ACCESS) & we_q & ~err_q;
    assign bus.mem_addr = word_q;
    assign bus.mem_wdat = wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= GNT_LOAD;
            we_q          <= 1'b0;
            err_q         <= 1'b0;
            word_q        <= '0;
            wdata_q       <= '0;
            c_rsp_valid_q <= 1'b0;
            c_rsp_err_q   <= 1'b0;
            c_rsp_rdata_q <= '0;
            l_rsp_valid_q <= 1'b0;
            l_rsp_err_q   <= 1'b0;
            l_rsp_rdata_q <= '0;
        end else begin
            // Responses are single-cycle pulses; clear unless set below.
            c_rsp_valid_q <= 1'b0;
            c_rsp_err_q   <= 1'b0;
            c_rsp_rdata_q <= '0;
            l_rsp_valid_q <= 1'b0;
            l_rsp_err_q   <= 1'b0;
            l_rsp_rdata_q <= '0;
            if (state_q == ST_IDLE) begin
                if (accept) begin
                    state_q      <= ST_ACCESS;
                    // gnt[1] set means the loader won, which encodes as GNT_LOAD.
                    last_grant_q <= gnt[1];
                    we_q         <= sel_we;
                    err_q        <= addr_err(sel_addr, MEM_AW);
                    word_q       <= sel_addr[MEM_AW+1:2];
                    wdata_q      <= sel_wdata;
                end
            end else begin
                state_q <= ST_IDLE;
                // last_grant_q doubles as the id of the port being served.
                if (last_grant_q == GNT_LOAD) begin
                    l_rsp_valid_q <= 1'b1;
                    l_rsp_err_q   <= err_q;
                    l_rsp_rdata_q <= rsp_rdata;
                end else begin
                    c_rsp_valid_q <= 1'b1;
                    c_rsp_err_q   <= err_q;
                    c_rsp_rdata_q <= rsp_rdata;
                end
            end
        end
    end

    assign bus.c_rsp_valid = c_rsp_valid_q;
    assign bus.c_rsp_err   = c_rsp_err_q;
    assign bus.c_rsp_rdata = c_rsp_rdata_q;
    assign bus.l_rsp_valid = l_rsp_valid_q;
    assign bus.l_rsp_err   = l_rsp_err_q;
    assign bus.l_rsp_rdata = l_rsp_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a behavioural memory, a reference
// memory image and a scoreboard of expected responses filled at handshake.
module tb_dmem_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 6;

    typedef struct {
        int          port;
        logic        we;
        logic        err;
        logic [5:0]  word;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.DATA_W(DW), .MEM_AW(AW)) bus ();

    dmem_arbiter #(.DATA_W(DW), .MEM_AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    bit          mem_init = 1'b0;
    bit          ref_init = 1'b0;

    exp_t sb[$];
    int   grant_log[$];
    int   accept_cyc[$];
    int   wen_cycles = 0;
    int   cyc = 0;
    bit   in_access = 1'b0;
    int   n_checks = 0;
    int   n_fails = 0;

    function automatic logic [31:0] init_word(input int i);
        init_word = (i == 4) ? 32'hDEAD_BEEF : (32'hA500_0000 | i);
    endfunction

    function automatic logic pred_err(input logic [31:0] addr);
        pred_err = (addr[1:0] != 2'b00) || (addr[31:8] != 24'd0);
    endfunction

    function automatic int log_at(input int i);
        log_at = (i < grant_log.size()) ? grant_log[i] : -1;
    endfunction

    function automatic int acc_at(input int i);
        acc_at = (i < accept_cyc.size()) ? accept_cyc[i] : -100;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Memory model: combinational read, write at the clock edge.
    assign bus.mem_rdat = mem[bus.mem_addr];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
            mem_init <= 1'b1;
        end else if (bus.mem_wen) begin
            mem[bus.mem_addr] <= bus.mem_wdat;
        end
    end

    // Monitor / scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        logic c_acc, l_acc;
        if (!ref_init) begin
            for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
            ref_init = 1'b1;
        end
        if (!rst_n) begin
            sb.delete();
            in_access = 1'b0;
        end else begin
            check("ready_onehot", bus.c_req_ready & bus.l_req_ready, 0);
            check("ready_in_access", (bus.c_req_ready | bus.l_req_ready) & in_access, 0);
            check("rsp_onehot", bus.c_rsp_valid & bus.l_rsp_valid, 0);

            if (bus.c_rsp_valid || bus.l_rsp_valid) begin
                check("rsp_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("rsp_port", bus.l_rsp_valid, e.port);
                    check("rsp_cycle", cyc, e.cyc + 2);
                    if (bus.l_rsp_valid) begin
                        check("l_rsp_err", bus.l_rsp_err, e.err);
                        check("l_rsp_rdata", bus.l_rsp_rdata, e.rdata);
                        check("c_rsp_quiet", bus.c_rsp_rdata | bus.c_rsp_err, 0);
                    end else begin
                        check("c_rsp_err", bus.c_rsp_err, e.err);
                        check("c_rsp_rdata", bus.c_rsp_rdata, e.rdata);
                        check("l_rsp_quiet", bus.l_rsp_rdata | bus.l_rsp_err, 0);
                    end
                    if (e.we && !e.err) ref_mem[e.word] = e.wdata;
                end
            end

            if (bus.mem_wen) begin
                wen_cycles++;
                check("wen_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    check("wen_legal", sb[0].we && !sb[0].err, 1);
                    check("wen_addr", bus.mem_addr, sb[0].word);
                    check("wen_data", bus.mem_wdat, sb[0].wdata);
                end
            end

            c_acc = bus.c_req_valid & bus.c_req_ready;
            l_acc = bus.l_req_valid & bus.l_req_ready;
            if (c_acc || l_acc) begin
                e.port  = l_acc ? 1 : 0;
                e.we    = l_acc ? bus.l_req_we : bus.c_req_we;
                e.wdata = l_acc ? bus.l_req_wdata : bus.c_req_wdata;
                e.err   = pred_err(l_acc ? bus.l_req_addr : bus.c_req_addr);
                e.word  = l_acc ? bus.l_req_addr[7:2] : bus.c_req_addr[7:2];
                e.rdata = (!e.we && !e.err) ? ref_mem[e.word] : 32'd0;
                e.cyc   = cyc;
                sb.push_back(e);
                grant_log.push_back(e.port);
                accept_cyc.push_back(cyc);
            end
            in_access = c_acc | l_acc;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int port, input logic we, input logic [31:0] addr,
                           input logic [31:0] wd);
        if (port == 0) begin
            bus.c_req_we = we; bus.c_req_addr = addr; bus.c_req_wdata = wd;
            bus.c_req_valid = 1'b1;
        end else begin
            bus.l_req_we = we; bus.l_req_addr = addr; bus.l_req_wdata = wd;
            bus.l_req_valid = 1'b1;
        end
    endtask

    // Present a request and wait (bounded) for its handshake; returns one
    // step after the accepting edge with the request still valid.
    task automatic send(input int port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd);
        int n;
        logic got;
        n = 0;
        got = 1'b0;
        set_req(port, we, addr, wd);
        while (!got && n < 20) begin
            @(negedge clk);
            got = (port == 0) ? bus.c_req_ready : bus.l_req_ready;
            n++;
        end
        check("accept_in_time", got, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drop_all();
        bus.c_req_valid = 1'b0;
        bus.l_req_valid = 1'b0;
    endtask

    task automatic do_reset();
        drop_all();
        rst_n = 1'b0;
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(1);
    endtask

    initial begin
        int start;
        int wen0;
        drop_all();
        bus.c_req_we = 1'b0; bus.c_req_addr = '0; bus.c_req_wdata = '0;
        bus.l_req_we = 1'b0; bus.l_req_addr = '0; bus.l_req_wdata = '0;

        // Reset values
        rst_n = 1'b0;
        wait_cycles(2);
        check("rst_c_ready", bus.c_req_ready, 0);
        check("rst_l_ready", bus.l_req_ready, 0);
        check("rst_c_valid", bus.c_rsp_valid, 0);
        check("rst_l_valid", bus.l_rsp_valid, 0);
        check("rst_c_err", bus.c_rsp_err, 0);
        check("rst_l_err", bus.l_rsp_err, 0);
        check("rst_c_rdata", bus.c_rsp_rdata, 0);
        check("rst_l_rdata", bus.l_rsp_rdata, 0);
        check("rst_mem_wen", bus.mem_wen, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdat", bus.mem_wdat, 0);
        rst_n = 1'b1;
        wait_cycles(1);

        // Both ports pending for 8 cycles straight out of reset
        start = grant_log.size();
        wen0 = wen_cycles;
        set_req(0, 1'b0, 32'h10, 32'h0);
        set_req(1, 1'b1, 32'h08, 32'h1234_5678);
        wait_cycles(8);
        drop_all();
        wait_cycles(3);
        check("rr_count", grant_log.size() - start, 4);
        check("rr_g0", log_at(start), 0);
        check("rr_g1", log_at(start + 1), 1);
        check("rr_g2", log_at(start + 2), 0);
        check("rr_g3", log_at(start + 3), 1);
        check("rr_wen_cycles", wen_cycles - wen0, 2);
        check("rr_mem_word2", mem[2], 32'h1234_5678);

        // Single core load of word 4
        send(0, 1'b0, 32'h10, 32'h0);
        check("load_mem_addr", bus.mem_addr, 4);
        check("load_no_wen", bus.mem_wen, 0);
        drop_all();
        wait_cycles(3);

        // Misaligned core store and out-of-range loader load
        wen0 = wen_cycles;
        send(0, 1'b1, 32'h0000_0102, 32'hBAD0_BAD0);
        drop_all();
        send(1, 1'b0, 32'h0000_0100, 32'h0);
        drop_all();
        wait_cycles(3);
        check("err_no_wen", wen_cycles - wen0, 0);

        // Back-to-back core requests, including a read-after-write
        start = accept_cyc.size();
        send(0, 1'b0, 32'h10, 32'h0);
        send(0, 1'b1, 32'h14, 32'h55AA_55AA);
        send(0, 1'b0, 32'h14, 32'h0);
        drop_all();
        wait_cycles(3);
        check("b2b_gap1", acc_at(start + 1) - acc_at(start), 2);
        check("b2b_gap2", acc_at(start + 2) - acc_at(start + 1), 2);

        // Reset during the ACCESS cycle of a store
        send(0, 1'b1, 32'h20, 32'hCAFE_F00D);
        check("pre_rst_wen", bus.mem_wen, 1);
        drop_all();
        #1 rst_n = 1'b0;
        #1;
        check("rst_abort_wen", bus.mem_wen, 0);
        check("rst_abort_rsp", bus.c_rsp_valid, 0);
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(1);
        check("rst_abort_mem", mem[8], ref_mem[8]);
        start = grant_log.size();
        set_req(0, 1'b0, 32'h20, 32'h0);
        set_req(1, 1'b0, 32'h24, 32'h0);
        wait_cycles(2);
        drop_all();
        wait_cycles(3);
        check("post_rst_first", log_at(start), 0);

        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
